ring_counter_ctl: RTL

Parametrised one-hot ring / twisted-ring (Johnson) counter for phase sequencing in the counter library. It extends the fixed 4-bit ring by adding configurable width and mode, enable, direction, parallel load, and a binary phase index. It also detects illegal states and recovers from them automatically. It drives phase-select and strobe logic that needs a glitch-free decoded sequence plus a wrap marker.

---
 rtl/ring_counter_ctl.sv | 110 +++++++++++
 1 files changed

// File: rtl/ring_counter_ctl.sv
// One-hot ring / Johnson phase counter with enable, direction, parallel load,
// registered binary phase index, wrap marker and self-correction of illegal states.
module ring_counter_ctl #(
    parameter int unsigned WIDTH   = 4,
    parameter bit          JOHNSON = 1'b0,
    localparam int unsigned PERIOD = JOHNSON ? 2 * WIDTH : WIDTH,
    localparam int unsigned IDXW   = $clog2(PERIOD)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] q_o,
    output logic [IDXW-1:0]  idx_o,
    output logic             wrap_o,
    output logic             err_o
);

    localparam logic [WIDTH-1:0] RST_Q    = JOHNSON ? '0 : WIDTH'(1);
    localparam logic [IDXW-1:0]  IDX_LAST = IDXW'(PERIOD - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             fb_up, fb_dn;

    // Johnson legal patterns are thermometer codes filled from the bottom
    // (ones low) or, once the top bit is set, from the top (zeros low).
    function automatic logic is_legal(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] n;
        if (!JOHNSON) begin
            return $onehot(v);
        end
        n = ~v;
        return ((v & (v + WIDTH'(1))) == '0) || ((n & (n + WIDTH'(1))) == '0);
    endfunction

    function automatic logic [IDXW-1:0] index_of(input logic [WIDTH-1:0] v);
        int unsigned pos;
        int unsigned cnt;
        pos = 0;
        cnt = 0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                pos = i;
                cnt++;
            end
        end
        if (!JOHNSON) begin
            return IDXW'(pos);
        end
        if (v[WIDTH-1]) begin
            return IDXW'(2 * WIDTH - cnt);
        end
        return IDXW'(cnt);
    endfunction

    assign fb_up = JOHNSON ? ~q_q[WIDTH-1] : q_q[WIDTH-1];
    assign fb_dn = JOHNSON ? ~q_q[0] : q_q[0];

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (load_i) begin
            if (is_legal(load_val_i)) begin
                q_d = load_val_i;
            end else begin
                q_d   = RST_Q;
                err_d = 1'b1;
            end
        end else if (!is_legal(q_q)) begin
            q_d   = RST_Q;
            err_d = 1'b1;
        end else if (en_i) begin
            if (!dir_i) begin
                q_d    = {q_q[WIDTH-2:0], fb_up};
                wrap_d = (idx_q == IDX_LAST);
            end else begin
                q_d    = {fb_dn, q_q[WIDTH-1:1]};
                wrap_d = (idx_q == '0);
            end
        end
        // Index is re-derived from the next state so it always tracks q.
        idx_d = index_of(q_d);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            q_q    <= RST_Q;
            idx_q  <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign q_o    = q_q;
    assign idx_o  = idx_q;
    assign wrap_o = wrap_q;
    assign err_o  = err_q;

endmodule
